sha_schedule: RTL

SHA_SCHEDULE -- requirements
Module: sha_schedule

---
 rtl/sha_schedule.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sha_schedule.sv
// SHA-1 / SHA-2 message schedule: loads a 16-word block, then streams W[t] one word per round.
// First word the cycle after the 16th load; out_ready=0 freezes the output word, round and last flag.
package sha;
   typedef enum logic [2:0] {
      SHA1       = 3'd0,
      SHA224     = 3'd1,
      SHA256     = 3'd2,
      SHA384     = 3'd3,
      SHA512     = 3'd4,
      SHA512_224 = 3'd5,
      SHA512_256 = 3'd6
   } mode_t;
endpackage

module sha_schedule #(
   parameter int ROUND_W = 7
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  sha::mode_t         mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [63:0]        in_word,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [63:0]        out_w,
   output logic [ROUND_W-1:0] out_round,
   output logic               out_last,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   sha::mode_t         mode_q;
   logic [63:0]        buf_q [16];
   logic [3:0]         load_cnt;
   logic [ROUND_W-1:0] t_q;
   logic [ROUND_W-1:0] last_t;
   logic               is_sha1;
   logic               is_32;
   logic               at_last;
   logic               load_fire;
   logic               round_fire;

   logic [31:0] sha1_x;
   logic [31:0] s0_32;
   logic [31:0] s1_32;
   logic [31:0] sum_32;
   logic [63:0] s0_64;
   logic [63:0] s1_64;
   logic [63:0] sum_64;
   logic [63:0] next_w;

   assign is_sha1 = (mode_q == sha::SHA1);
   assign is_32   = is_sha1 || (mode_q == sha::SHA224) || (mode_q == sha::SHA256);
   assign last_t  = ((mode_q == sha::SHA224) || (mode_q == sha::SHA256)) ? ROUND_W'(63) : ROUND_W'(79);
   assign at_last = (t_q == last_t);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && (load_cnt == 4'd15)) begin
               state_nxt = ROUND;
            end
         end
         ROUND: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready && at_last) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign load_fire  = in_ready && in_valid;
   assign round_fire = out_valid && out_ready;

   // Output word is gated so IDLE/LOAD never expose stale buffer contents.
   assign out_w     = out_valid ? buf_q[0] : 64'h0;
   assign out_round = t_q;
   assign out_last  = out_valid && at_last;

   // Next schedule word from the sliding window: buf_q[i] holds W[t+i].
   assign sha1_x = buf_q[13][31:0] ^ buf_q[8][31:0] ^ buf_q[2][31:0] ^ buf_q[0][31:0];

   assign s0_32  = {buf_q[1][6:0], buf_q[1][31:7]} ^ {buf_q[1][17:0], buf_q[1][31:18]}
                 ^ {3'b000, buf_q[1][31:3]};
   assign s1_32  = {buf_q[14][16:0], buf_q[14][31:17]} ^ {buf_q[14][18:0], buf_q[14][31:19]}
                 ^ {10'h000, buf_q[14][31:10]};
   assign sum_32 = s1_32 + buf_q[9][31:0] + s0_32 + buf_q[0][31:0];

   assign s0_64  = {buf_q[1][0], buf_q[1][63:1]} ^ {buf_q[1][7:0], buf_q[1][63:8]}
                 ^ {7'h00, buf_q[1][63:7]};
   assign s1_64  = {buf_q[14][18:0], buf_q[14][63:19]} ^ {buf_q[14][60:0], buf_q[14][63:61]}
                 ^ {6'h00, buf_q[14][63:6]};
   assign sum_64 = s1_64 + buf_q[9] + s0_64 + buf_q[0];

   always_comb begin
      next_w = sum_64;
      if (is_sha1) begin
         next_w = {32'h0, sha1_x[30:0], sha1_x[31]};
      end else if (is_32) begin
         next_w = {32'h0, sum_32};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_q   <= sha::SHA1;
         load_cnt <= 4'd0;
         t_q      <= '0;
         for (int i = 0; i < 16; i++) begin
            buf_q[i] <= 64'h0;
         end
      end else begin
         if ((state == IDLE) && start) begin
            mode_q   <= mode;
            load_cnt <= 4'd0;
            t_q      <= '0;
         end
         if (load_fire) begin
            buf_q[load_cnt] <= is_32 ? {32'h0, in_word[31:0]} : in_word;
            load_cnt        <= load_cnt + 4'd1;
         end
         if (round_fire) begin
            for (int i = 0; i < 15; i++) begin
               buf_q[i] <= buf_q[i+1];
            end
            buf_q[15] <= next_w;
            t_q       <= at_last ? '0 : t_q + ROUND_W'(1);
         end
      end
   end

endmodule
